// File: rtl/random_sequence_checker_if.sv
// Bus bundle between a JK sequence counter output and its receive-side checker.
// Combinational bundle only; no latency of its own.
// No backpressure: the checker samples q_in on every edge that sample_en is high.
//
// Signals:
//   q_in       [1:4]   observed counter code, q_in[1] is the MSB
//   sample_en          1 = q_in is sampled on this edge
//   locked             checker is tracking the sequence
//   match              1-cycle pulse, sample equalled the prediction
//   err                mismatch flag (pulse or sticky, see checker header)
//   index      [2:0]   cycle position of the last accepted code
//   expected   [1:4]   predicted next code
//   err_count  CNT_W   saturating mismatch count
// Modports: master = code source / observer, slave = checker.
interface random_sequence_checker_if #(
    parameter int CNT_W = 8
);
    logic [1:4]       q_in;
    logic             sample_en;
    logic             locked;
    logic             match;
    logic             err;
    logic [2:0]       index;
    logic [1:4]       expected;
    logic [CNT_W-1:0] err_count;

    modport master (
        output q_in,
        output sample_en,
        input  locked,
        input  match,
        input  err,
        input  index,
        input  expected,
        input  err_count
    );

    modport slave (
        input  q_in,
        input  sample_en,
        output locked,
        output match,
        output err,
        output index,
        output expected,
        output err_count
    );
endinterface

// File: rtl/random_sequence_checker.sv
// Locks onto and checks the 8-state JK sequence 0,D,B,9,6,C,3,F,0,...
// Latency: all outputs registered, valid 1 clk after the sampling edge.
// Backpressure: none; samples are taken whenever sample_en is high.
//
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high reset; wins over sample_en
//   bus    random_sequence_checker_if.slave (q_in/sample_en in, status out)
// Parameters:
//   LOCK_LEN  consecutive in-order valid codes needed to lock (>=1)
//   LOSS_LEN  consecutive mismatches while locked that drop lock (>=1)
//   CNT_W     width of err_count; must match the interface CNT_W
// Build option:
//   RSEQ_ERR_STICKY_EN  when defined, err latches on the first mismatch
//                       and holds until clear; otherwise err pulses once
//                       per mismatching sample.
module random_sequence_checker #(
    parameter int LOCK_LEN = 3,
    parameter int LOSS_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         clear,
    random_sequence_checker_if.slave     bus
);

    localparam int RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int MISS_W = $clog2(LOSS_LEN + 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Sequence table: position -> code.
    function automatic logic [3:0] f_code(input logic [2:0] pos);
        logic [3:0] c;
        case (pos)
            3'd0:    c = 4'h0;
            3'd1:    c = 4'hD;
            3'd2:    c = 4'hB;
            3'd3:    c = 4'h9;
            3'd4:    c = 4'h6;
            3'd5:    c = 4'hC;
            3'd6:    c = 4'h3;
            default: c = 4'hF;
        endcase
        return c;
    endfunction

    // Inverse table; invalid codes map to 0 and must be gated by f_valid.
    function automatic logic [2:0] f_pos(input logic [3:0] code);
        logic [2:0] p;
        case (code)
            4'h0:    p = 3'd0;
            4'hD:    p = 3'd1;
            4'hB:    p = 3'd2;
            4'h9:    p = 3'd3;
            4'h6:    p = 3'd4;
            4'hC:    p = 3'd5;
            4'h3:    p = 3'd6;
            4'hF:    p = 3'd7;
            default: p = 3'd0;
        endcase
        return p;
    endfunction

    function automatic logic f_valid(input logic [3:0] code);
        logic v;
        case (code)
            4'h0, 4'hD, 4'hB, 4'h9,
            4'h6, 4'hC, 4'h3, 4'hF: v = 1'b1;
            default:                v = 1'b0;
        endcase
        return v;
    endfunction

    // ---------------- state ----------------
    state_t            r_state;
    logic              r_locked;
    logic              r_match;
    logic              r_err;
    logic [2:0]        r_index;
    logic [3:0]        r_expected;
    logic [CNT_W-1:0]  r_err_count;
    logic [3:0]        r_prev;
    logic [RUN_W-1:0]  r_run;
    logic [MISS_W-1:0] r_miss;

    // ---------------- decode ----------------
    state_t            w_state_nxt;
    logic [3:0]        w_q;
    logic              w_q_valid;
    logic [2:0]        w_q_pos;
    logic [3:0]        w_prev_succ;
    logic [RUN_W-1:0]  w_run_hunt;
    logic              w_lock_hit;
    logic              w_mismatch;
    logic [MISS_W-1:0] w_miss_inc;
    logic              w_loss_hit;

    logic              w_locked_nxt;
    logic              w_match_nxt;
    logic              w_err_nxt;
    logic [2:0]        w_index_nxt;
    logic [3:0]        w_expected_nxt;
    logic [CNT_W-1:0]  w_err_count_nxt;
    logic [3:0]        w_prev_nxt;
    logic [RUN_W-1:0]  w_run_nxt;
    logic [MISS_W-1:0] w_miss_nxt;

    assign w_q         = bus.q_in;
    assign w_q_valid   = f_valid(w_q);
    assign w_q_pos     = f_pos(w_q);
    assign w_prev_succ = f_code(f_pos(r_prev) + 3'd1);

    // Hunt run length after this sample. r_run > 0 guarantees r_prev was
    // a valid code, so its successor lookup is meaningful.
    always_comb begin
        w_run_hunt = '0;
        if (!w_q_valid) begin
            w_run_hunt = '0;
        end else if ((r_run != '0) && (w_q == w_prev_succ)) begin
            w_run_hunt = r_run + RUN_W'(1);
        end else begin
            w_run_hunt = RUN_W'(1);
        end
    end

    // r_run stays below LOCK_LEN and r_miss below LOSS_LEN, so the
    // incremented values always fit their widths.
    assign w_lock_hit = bus.sample_en && (w_run_hunt == RUN_W'(LOCK_LEN));
    assign w_mismatch = (w_q != r_expected);
    assign w_miss_inc = r_miss + MISS_W'(1);
    assign w_loss_hit = bus.sample_en && w_mismatch && (w_miss_inc == MISS_W'(LOSS_LEN));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT:   if (w_lock_hit) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_loss_hit) w_state_nxt = ST_HUNT;
            default:   w_state_nxt = ST_HUNT;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        w_locked_nxt    = r_locked;
        w_match_nxt     = 1'b0;
`ifdef RSEQ_ERR_STICKY_EN
        w_err_nxt       = r_err;
`else
        w_err_nxt       = 1'b0;
`endif
        w_index_nxt     = r_index;
        w_expected_nxt  = r_expected;
        w_err_count_nxt = r_err_count;
        w_prev_nxt      = r_prev;
        w_run_nxt       = r_run;
        w_miss_nxt      = r_miss;

        if (bus.sample_en) begin
            case (r_state)
                ST_HUNT: begin
                    w_prev_nxt = w_q;
                    w_run_nxt  = w_run_hunt;
                    if (w_lock_hit) begin
                        w_locked_nxt   = 1'b1;
                        w_index_nxt    = w_q_pos;
                        w_expected_nxt = f_code(w_q_pos + 3'd1);
                        w_run_nxt      = '0;
                        w_miss_nxt     = '0;
                    end
                end
                ST_LOCKED: begin
                    // Position advances whether or not the sample matched,
                    // so a single corrupted code does not desynchronise us.
                    w_index_nxt    = r_index + 3'd1;
                    w_expected_nxt = f_code(r_index + 3'd2);
                    if (!w_mismatch) begin
                        w_match_nxt = 1'b1;
                        w_miss_nxt  = '0;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (r_err_count != {CNT_W{1'b1}}) begin
                            w_err_count_nxt = r_err_count + CNT_W'(1);
                        end
                        if (w_loss_hit) begin
                            w_locked_nxt = 1'b0;
                            w_run_nxt    = '0;
                            w_miss_nxt   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_locked    <= 1'b0;
            r_match     <= 1'b0;
            r_err       <= 1'b0;
            r_index     <= 3'd0;
            r_expected  <= 4'h0;
            r_err_count <= '0;
            r_prev      <= 4'h0;
            r_run       <= '0;
            r_miss      <= '0;
        end else begin
            r_locked    <= w_locked_nxt;
            r_match     <= w_match_nxt;
            r_err       <= w_err_nxt;
            r_index     <= w_index_nxt;
            r_expected  <= w_expected_nxt;
            r_err_count <= w_err_count_nxt;
            r_prev      <= w_prev_nxt;
            r_run       <= w_run_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    assign bus.locked    = r_locked;
    assign bus.match     = r_match;
    assign bus.err       = r_err;
    assign bus.index     = r_index;
    assign bus.expected  = r_expected;
    assign bus.err_count = r_err_count;

endmodule
